// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO plus launch FSM feeding uart_tx: one o_Tx_DV strobe per queued byte, each gated on the previous frame's o_Tx_Done.
// Optional o_Level port (registered fill count) is enabled by defining UART_TX_FIFO_LEVEL_EN.
module uart_tx_fifo_feeder #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic              o_Overflow,
  input  logic              i_Clr_Ovf,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]   o_Level
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    GAP
  } state_t;

  state_t state, state_next;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push, pop;

  assign o_Full  = (count == (ADDR_W+1)'(DEPTH));
  assign o_Empty = (count == '0);

  // Full is the pre-edge value, so a write into a full FIFO is dropped even if a pop happens on the same edge.
  assign push = i_Wr_DV && !o_Full;
  assign pop  = (state == IDLE) && !o_Empty && !i_Tx_Active;

  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem[wr_ptr] <= i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Overflow <= 1'b0;
    end else if (i_Wr_DV && o_Full) begin
      o_Overflow <= 1'b1;
    end else if (i_Clr_Ovf) begin
      o_Overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = WAIT_DONE;
      WAIT_DONE: if (i_Tx_Done) state_next = GAP;
      GAP:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The launch strobe and byte are registered, so a byte written at edge N launches after edge N+1 at the earliest.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      o_Tx_DV <= pop;
      if (pop) begin
        o_Tx_Byte <= mem[rd_ptr];
      end
    end
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  assign o_Level = count;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Self-checking bench for uart_tx_fifo_feeder: table vectors, directed timing sequences and random traffic
// against a queue-based reference model, with a behavioural stand-in for uart_tx.
module tb_uart_tx_fifo_feeder;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_dv = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       full, empty, ovf, tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done = 1'b0;
  logic       busy = 1'b0;
  logic       hold = 1'b0;
  int unsigned cnt = 0;
  int unsigned frame_len = 6;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int launches = 0;
  logic [7:0] mq[$];
  logic exp_ovf = 1'b0;

  typedef struct {
    logic       wr;
    logic [7:0] b;
    logic       clr;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;
  vec_t tbl[21];

  uart_tx_fifo_feeder #(.DEPTH(DEPTH)) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Wr_DV    (wr_dv),
    .i_Wr_Byte  (wr_byte),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Overflow (ovf),
    .i_Clr_Ovf  (clr_ovf),
    .o_Tx_DV    (tx_dv),
    .o_Tx_Byte  (tx_byte),
    .i_Tx_Active(tx_active),
    .i_Tx_Done  (tx_done)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .o_Level    (level)
`endif
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: never reset, busy for frame_len cycles per strobe, then a one-cycle done pulse.
  // hold stretches the active flag to emulate a long frame in flight.
  assign tx_active = busy | hold;
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (busy) begin
      if (cnt <= 1) begin
        busy    <= 1'b0;
        tx_done <= 1'b1;
      end
      cnt <= cnt - 1;
    end else if (tx_dv) begin
      busy <= 1'b1;
      cnt  <= frame_len;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance, then update the reference queue and compare the visible state.
  task automatic tick(input logic wr, input logic [7:0] b, input logic clr);
    logic full_pre;
    full_pre = (mq.size() == DEPTH);
    wr_dv    = wr;
    wr_byte  = b;
    clr_ovf  = clr;
    if (wr && full_pre) exp_ovf = 1'b1;
    else if (clr)       exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    wr_dv   = 1'b0;
    clr_ovf = 1'b0;
    if (wr && !full_pre) mq.push_back(b);
    if (tx_dv) begin
      launches++;
      chk("dv_while_active", tx_active, 0);
      if (mq.size() == 0) chk("launch_unexpected", 1, 0);
      else                chk("launch_byte", tx_byte, mq.pop_front());
    end
    chk("full", full, (mq.size() == DEPTH));
    chk("empty", empty, (mq.size() == 0));
    chk("overflow", ovf, exp_ovf);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("level", level, mq.size());
`endif
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 5000; i++) begin
      if (mq.size() == 0 && !tx_active && !tx_dv) quiet++;
      else quiet = 0;
      if (quiet >= 4) return;
      tick(1'b0, 8'h00, 1'b0);
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_dv(input string name);
    for (int i = 0; i < 500; i++) begin
      if (tx_dv) return;
      tick(1'b0, 8'h00, 1'b0);
    end
    chk(name, 0, 1);
  endtask

  initial begin
    int n;
    int l0;
    int guard;

    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 8'(i), 1'b0, (i == 15), 1'b0, 1'b0};
    tbl[16] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tx_dv", tx_dv, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("rst_level", level, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill / overflow / clear table with the transmitter held busy
    hold = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick(tbl[i].wr, tbl[i].b, tbl[i].clr);
      chk("tbl_full", full, tbl[i].full);
      chk("tbl_empty", empty, tbl[i].empty);
      chk("tbl_ovf", ovf, tbl[i].ovf);
    end
    hold = 1'b0;
    drain();

    // First launch latency: written at edge N, strobe visible only after edge N+1, for one cycle
    frame_len = 6;
    tick(1'b1, 8'hA5, 1'b0);
    chk("lat_n", tx_dv, 0);
    tick(1'b0, 8'h00, 1'b0);
    chk("lat_n1", tx_dv, 1);
    chk("lat_byte", tx_byte, 8'hA5);
    tick(1'b0, 8'h00, 1'b0);
    chk("lat_pulse", tx_dv, 0);
    drain();

    // Back-to-back spacing: next strobe three edges after the done pulse is seen
    hold = 1'b1;
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    hold = 1'b0;
    guard = 0;
    while (!tx_done && guard < 200) begin
      tick(1'b0, 8'h00, 1'b0);
      guard++;
    end
    chk("b2b_done_seen", tx_done, 1);
    n = 0;
    while (!tx_dv && n < 20) begin
      tick(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("b2b_gap", n, 3);
    drain();

    // 17 back-to-back writes while the first frame is in flight, then one dropped write
    frame_len = 30;
    for (int i = 0; i <= 16; i++) tick(1'b1, 8'(i), 1'b0);
    chk("burst_full", full, 1);
    chk("burst_no_ovf", ovf, 0);
    tick(1'b1, 8'hFF, 1'b0);
    chk("burst_ovf", ovf, 1);
    tick(1'b0, 8'h00, 1'b1);
    chk("burst_clr", ovf, 0);
    drain();

    // Sweep every byte value, writing whenever there is room
    frame_len = 3;
    l0 = launches;
    for (int b = 0; b < 256; b++) begin
      guard = 0;
      while (mq.size() == DEPTH && guard < 1000) begin
        tick(1'b0, 8'h00, 1'b0);
        guard++;
      end
      tick(1'b1, 8'(b), 1'b0);
    end
    drain();
    chk("sweep_count", launches - l0, 256);
    chk("sweep_empty", empty, 1);

    // Random traffic against the reference queue
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) frame_len = $urandom_range(1, 12);
      tick(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 19) == 0));
    end
    drain();

    // Reset in the middle of a frame: FIFO discarded, no launch until the in-flight frame ends
    frame_len = 40;
    hold = 1'b1;
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    tick(1'b1, 8'h03, 1'b0);
    hold = 1'b0;
    wait_dv("rst_first_launch_timeout");
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("rst_mid_active", tx_active, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_dv", tx_dv, 0);
    chk("rst_mid_ovf", ovf, 0);
    mq.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 8'h3C, 1'b0);
    guard = 0;
    while (tx_active && guard < 200) begin
      chk("rst_no_dv", tx_dv, 0);
      tick(1'b0, 8'h00, 1'b0);
      guard++;
    end
    wait_dv("rst_3c_timeout");
    chk("rst_3c_byte", tx_byte, 8'h3C);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
